// File: rtl/wb_burst_sram_slave.sv
// Wishbone B3 burst-capable SRAM responder: classic cycles and incrementing (cti 010) bursts.
// Optional WB_SRAM_SLAVE_ERR_EN adds err_o for out-of-range addresses and wrapping bursts.
module wb_burst_sram_slave #(
  parameter int ADDR_BITS   = 13,
  parameter int WAIT_STATES = 1,
  parameter int BASE_ADDR   = 0
) (
  input  logic        clock_i,
  input  logic        reset_n_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  input  logic [3:0]  sel_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [2:0]  cti_i,
  output logic        ack_o
`ifdef WB_SRAM_SLAVE_ERR_EN
  ,
  output logic        err_o
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_BEAT = 2'd2
  } state_t;

  localparam logic [3:0]           WS_INIT = 4'(WAIT_STATES);
  localparam logic [ADDR_BITS-1:0] PTR_ONE = ADDR_BITS'(1);

  logic [31:0]          mem_r [0:(1<<ADDR_BITS)-1];
  state_t               state_r, state_s;
  logic [3:0]           cnt_r, cnt_s;
  logic [ADDR_BITS-1:0] ptr_r, ptr_s;
  logic                 we_r, we_s;
  logic                 bad_r, bad_s;
  logic                 ack_r, ack_s;
  logic                 err_r, err_s;
  logic [31:0]          dat_r;
  logic                 req_s;
  logic                 beat_done_s;
  logic                 addr_bad_s;
  logic                 wrap_err_s;
  logic                 wr_en_s;

  assign req_s       = cyc_i & stb_i;
  assign beat_done_s = ack_r | err_r;
  // Writes only land on a real ack edge, so error beats and aborted cycles never touch memory.
  assign wr_en_s     = ack_r & req_s & we_r;
  assign ack_o       = ack_r;
  assign dat_o       = dat_r;

`ifdef WB_SRAM_SLAVE_ERR_EN
  localparam int                   UP_BITS = 30 - ADDR_BITS;
  localparam logic [UP_BITS-1:0]   BASE_UP = UP_BITS'(BASE_ADDR);
  localparam logic [ADDR_BITS-1:0] PTR_TOP = {ADDR_BITS{1'b1}};
  logic unused_s;
  assign addr_bad_s = (adr_i[31:ADDR_BITS+2] != BASE_UP);
  assign wrap_err_s = (ptr_r == PTR_TOP);
  assign unused_s   = ^adr_i[1:0];
  assign err_o      = err_r;
`else
  logic unused_s;
  assign addr_bad_s = 1'b0;
  assign wrap_err_s = 1'b0;
  assign unused_s   = ^{adr_i[31:ADDR_BITS+2], adr_i[1:0]};
`endif

  // Next-state, pointer and beat-acknowledge decode.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    ptr_s   = ptr_r;
    we_s    = we_r;
    bad_s   = bad_r;
    ack_s   = 1'b0;
    err_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_s) begin
          ptr_s = adr_i[ADDR_BITS+1:2];
          we_s  = we_i;
          bad_s = addr_bad_s;
          cnt_s = WS_INIT;
          if (WS_INIT != 4'd0) begin
            state_s = ST_WAIT;
          end else begin
            state_s = ST_BEAT;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!req_s) begin
          state_s = ST_IDLE;
          cnt_s   = 4'd0;
        end else if (cnt_r <= 4'd1) begin
          state_s = ST_BEAT;
          cnt_s   = 4'd0;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      ST_BEAT: begin
        if (!req_s) begin
          state_s = ST_IDLE;
        end else if (!beat_done_s) begin
          if (bad_r) begin
            err_s = 1'b1;
          end else begin
            ack_s = 1'b1;
          end
        end else if (err_r || (cti_i != 3'b010)) begin
          state_s = ST_IDLE;
        end else begin
          // Burst continues: next word is offered immediately, no new address needed.
          ptr_s = ptr_r + PTR_ONE;
          if (wrap_err_s) begin
            err_s = 1'b1;
          end else begin
            ack_s = 1'b1;
          end
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // Control registers and registered read data.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      ptr_r   <= {ADDR_BITS{1'b0}};
      we_r    <= 1'b0;
      bad_r   <= 1'b0;
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
      dat_r   <= 32'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      ptr_r   <= ptr_s;
      we_r    <= we_s;
      bad_r   <= bad_s;
      ack_r   <= ack_s;
      err_r   <= err_s;
      dat_r   <= ack_s ? mem_r[ptr_s] : 32'd0;
    end
  end

  // Byte-lane memory write; contents deliberately survive reset.
  always_ff @(posedge clock_i) begin
    if (wr_en_s) begin
      for (int i = 0; i < 4; i++) begin
        if (sel_i[i]) begin
          mem_r[ptr_r][8*i +: 8] <= dat_i[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_burst_sram_slave.sv
// Self-checking bench for wb_burst_sram_slave: read expectations go through a scoreboard queue.
module tb_wb_burst_sram_slave;

  localparam int WS = 1;

  logic        clock_i = 1'b0;
  logic        reset_n_i;
  logic [31:0] adr_i, dat_i, dat_o;
  logic [3:0]  sel_i;
  logic        cyc_i, stb_i, we_i, ack_o;
  logic [2:0]  cti_i;
`ifdef WB_SRAM_SLAVE_ERR_EN
  logic        err_o;
`endif

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] wdata [0:7];

  always #5 clock_i = ~clock_i;

  wb_burst_sram_slave #(.ADDR_BITS(13), .WAIT_STATES(WS), .BASE_ADDR(0)) dut (
    .clock_i  (clock_i),
    .reset_n_i(reset_n_i),
    .adr_i    (adr_i),
    .dat_i    (dat_i),
    .dat_o    (dat_o),
    .sel_i    (sel_i),
    .cyc_i    (cyc_i),
    .stb_i    (stb_i),
    .we_i     (we_i),
    .cti_i    (cti_i),
    .ack_o    (ack_o)
`ifdef WB_SRAM_SLAVE_ERR_EN
    ,
    .err_o    (err_o)
`endif
  );

  task automatic bus_idle();
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; cti_i = 3'b000; sel_i = 4'h0;
  endtask

  // Later beats scramble adr_i/we_i: the slave must keep using the latched values.
  task automatic drive_beat(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                            input int k, input int n, input logic [31:0] wd);
    cyc_i = 1'b1;
    stb_i = 1'b1;
    sel_i = sel;
    dat_i = wd;
    we_i  = (k == 0) ? we : ~we;
    adr_i = (k == 0) ? adr : $urandom;
    if (k == n - 1) cti_i = (n == 1) ? 3'b000 : 3'b111;
    else            cti_i = 3'b010;
  endtask

  // Runs an n-beat access; stops after `stop` beats (abort by cyc drop, or by reset if rst_abort).
  task automatic run_burst(input string name, input logic we, input logic [31:0] adr,
                           input logic [3:0] sel, input int n, input int stop, input bit rst_abort);
    int cyc_cnt = 0, done = 0, acks = 0, last_ack = 0;
    bit prev = 1'b0;
    logic [31:0] exp;
    drive_beat(we, adr, sel, 0, n, wdata[0]);
    while (done < stop && cyc_cnt < 40) begin
      @(posedge clock_i); #1;
      cyc_cnt++;
      if (prev) begin
        done++;
        if (done < stop) drive_beat(we, adr, sel, done, n, wdata[done]);
      end
      if (done < stop && ack_o) begin
        acks++;
        checks++;
        if (acks == 1 && cyc_cnt != WS + 2) begin
          failures++;
          $display("FAIL %s first_ack_cycle: got %0d expected %0d", name, cyc_cnt, WS + 2);
        end else if (acks > 1 && cyc_cnt != last_ack + 1) begin
          failures++;
          $display("FAIL %s ack_gap beat %0d: got cycle %0d expected %0d", name, acks, cyc_cnt, last_ack + 1);
        end
        last_ack = cyc_cnt;
        if (!we) begin
          exp = exp_q.pop_front();
          checks++;
          if (dat_o !== exp) begin
            failures++;
            $display("FAIL %s dat_o beat %0d: got %h expected %h", name, acks, dat_o, exp);
          end
        end
      end
      prev = ack_o;
    end
    checks++;
    if (done < stop) begin
      failures++;
      $display("FAIL %s timeout: beats %0d expected %0d", name, done, stop);
    end
    if (rst_abort) begin
      reset_n_i = 1'b0;
      #1;
      checks++;
      if (ack_o !== 1'b0 || dat_o !== 32'd0) begin
        failures++;
        $display("FAIL %s async_reset: ack_o=%b dat_o=%h expected 0/0", name, ack_o, dat_o);
      end
      bus_idle();
      #2 reset_n_i = 1'b1;
    end else begin
      bus_idle();
      if (stop != n) begin
        @(posedge clock_i); #1;
      end
      checks++;
      if (ack_o !== 1'b0) begin
        failures++;
        $display("FAIL %s ack_after_end: got %b expected 0", name, ack_o);
      end
    end
    @(posedge clock_i); #1;
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0;
    bus_idle();
    adr_i = 32'd0;
    dat_i = 32'd0;
    repeat (3) @(posedge clock_i);
    #1;
    checks++;
    if (ack_o !== 1'b0 || dat_o !== 32'd0) begin
      failures++;
      $display("FAIL reset_state: ack_o=%b dat_o=%h expected 0/0", ack_o, dat_o);
    end
`ifdef WB_SRAM_SLAVE_ERR_EN
    checks++;
    if (err_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_err: err_o=%b expected 0", err_o);
    end
`endif
    @(negedge clock_i) reset_n_i = 1'b1;
    @(posedge clock_i); #1;
  endtask

  task automatic test_single_read();
    wdata[0] = 32'hDEADBEEF;
    run_burst("wr_single", 1'b1, 32'h10, 4'hF, 1, 1, 1'b0);
    exp_q.push_back(32'hDEADBEEF);
    run_burst("rd_single", 1'b0, 32'h10, 4'hF, 1, 1, 1'b0);
  endtask

  task automatic test_burst_write();
    for (int k = 0; k < 8; k++) wdata[k] = 32'(k);
    run_burst("wr_burst", 1'b1, 32'h100, 4'hF, 8, 8, 1'b0);
  endtask

  task automatic test_burst_read();
    for (int k = 0; k < 8; k++) exp_q.push_back(32'(k));
    run_burst("rd_burst", 1'b0, 32'h100, 4'hF, 8, 8, 1'b0);
  endtask

  task automatic test_byte_write();
    wdata[0] = 32'h11223344;
    run_burst("wr_word", 1'b1, 32'h20, 4'hF, 1, 1, 1'b0);
    wdata[0] = 32'hAABBCCDD;
    run_burst("wr_byte", 1'b1, 32'h20, 4'b0100, 1, 1, 1'b0);
    exp_q.push_back(32'h11BB3344);
    run_burst("rd_byte", 1'b0, 32'h20, 4'hF, 1, 1, 1'b0);
  endtask

  task automatic test_abort();
    wdata[0] = 32'hCAFEF00D;
    run_burst("wr_mem0", 1'b1, 32'h0, 4'hF, 1, 1, 1'b0);
    for (int k = 0; k < 3; k++) exp_q.push_back(32'(k));
    run_burst("rd_abort", 1'b0, 32'h100, 4'hF, 8, 3, 1'b0);
    exp_q.push_back(32'hCAFEF00D);
    run_burst("rd_after_abort", 1'b0, 32'h0, 4'hF, 1, 1, 1'b0);
  endtask

`ifdef WB_SRAM_SLAVE_ERR_EN
  task automatic err_access(input string name, input logic we, input logic [31:0] adr,
                            input logic [31:0] wd);
    int errs = 0, acks = 0, first = 0;
    cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr; dat_i = wd; sel_i = 4'hF; cti_i = 3'b000;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clock_i); #1;
      if (first != 0 && c == first + 1) bus_idle();
      if (err_o) begin
        errs++;
        if (first == 0) first = c;
      end
      if (ack_o) acks++;
    end
    checks++;
    if (errs != 1 || acks != 0 || first != WS + 2) begin
      failures++;
      $display("FAIL %s: err cycles %0d acks %0d first %0d expected 1/0/%0d", name, errs, acks, first, WS + 2);
    end
  endtask

  task automatic test_err();
    err_access("err_read", 1'b0, 32'h8000_0000, 32'd0);
    err_access("err_write", 1'b1, 32'h8000_0000, 32'h12345678);
    exp_q.push_back(32'hCAFEF00D);
    run_burst("rd_after_err", 1'b0, 32'h0, 4'hF, 1, 1, 1'b0);
  endtask
`else
  task automatic test_alias();
    exp_q.push_back(32'hDEADBEEF);
    run_burst("rd_alias", 1'b0, 32'h8000_0010, 4'hF, 1, 1, 1'b0);
  endtask

  task automatic test_wrap();
    wdata[0] = 32'h0BADC0DE;
    run_burst("wr_top", 1'b1, 32'h7FFC, 4'hF, 1, 1, 1'b0);
    exp_q.push_back(32'h0BADC0DE);
    exp_q.push_back(32'hCAFEF00D);
    run_burst("rd_wrap", 1'b0, 32'h7FFC, 4'hF, 2, 2, 1'b0);
  endtask
`endif

  task automatic test_reset_mid_burst();
    for (int k = 0; k < 4; k++) wdata[k] = 32'hA0A0_0000 + 32'(k);
    run_burst("wr_rst", 1'b1, 32'h200, 4'hF, 4, 2, 1'b1);
    exp_q.push_back(32'hA0A0_0000);
    exp_q.push_back(32'hA0A0_0001);
    run_burst("rd_after_rst", 1'b0, 32'h200, 4'hF, 2, 2, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_burst_write();
    test_burst_read();
    test_byte_write();
    test_abort();
`ifdef WB_SRAM_SLAVE_ERR_EN
    test_err();
`else
    test_alias();
    test_wrap();
`endif
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
